// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the 9-bit RISC control path: opcodes, instruction
// fields and the sequencer state encoding.
package cpu_sequencer_pkg;

  localparam int INSTR_W = 9;
  localparam int OP_LSB  = 6;
  localparam int OP_W    = 3;

  localparam logic [OP_W-1:0] kADD = 3'd0;
  localparam logic [OP_W-1:0] kSUB = 3'd1;
  localparam logic [OP_W-1:0] kAND = 3'd2;
  localparam logic [OP_W-1:0] kXOR = 3'd3;
  localparam logic [OP_W-1:0] kLDI = 3'd4;
  localparam logic [OP_W-1:0] kLDM = 3'd5;
  localparam logic [OP_W-1:0] kSTR = 3'd6;
  localparam logic [OP_W-1:0] kBNE = 3'd7;

  // BNE branch offset: two's-complement field in the low instruction bits
  localparam int BNE_OFF_LSB = 0;
  localparam int BNE_OFF_W   = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_ERR
  } seq_state_t;

  function automatic logic is_parked(seq_state_t s);
    return (s == S_IDLE) || (s == S_HALT) || (s == S_ERR);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer-side bundle: ROM, decoder, compare, data-memory and status signals.
// master = the sequencer, slave = the surrounding core/environment.
interface cpu_sequencer_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  import cpu_sequencer_pkg::*;

  logic                 start;
  logic [INSTR_W-1:0]   instr;
  logic [OP_W-1:0]      op;
  logic                 dec_str;
  logic                 dec_ldr;
  logic                 dec_rf_we;
  logic                 bne_taken;
  logic [PC_W-1:0]      pc;
  logic                 mem_req;
  logic                 mem_we;
  logic                 mem_ack;
  logic                 rf_we;
  logic                 wb_sel_mem;
  logic                 busy;
  logic                 halted;
  logic                 err;
  logic [CNT_W-1:0]     retired;

  modport master (
    input  start, instr, dec_str, dec_ldr, dec_rf_we, bne_taken, mem_ack,
    output op, pc, mem_req, mem_we, rf_we, wb_sel_mem, busy, halted, err, retired
  );

  modport slave (
    output start, instr, dec_str, dec_ldr, dec_rf_we, bne_taken, mem_ack,
    input  op, pc, mem_req, mem_we, rf_we, wb_sel_mem, busy, halted, err, retired
  );

endinterface

// File: rtl/cpu_sequencer_wait_timer.sv
// Data-memory wait timer: down-counter reloaded outside MEM, flags timeout on
// the last permitted MEM cycle without an acknowledge.
module seq_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  input  logic ack_i,
  output logic timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i) begin
      cnt_d = LOAD;
    end else if (!ack_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ack in the terminal cycle takes priority over the timeout
  assign timeout_o = run_i && !ack_i && (cnt_q == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: owns pc, IR, the data-memory
// handshake, halt/error detection and the retired-instruction counter.
//
//   state   | meaning
//   IDLE    | out of reset, waiting for start
//   FETCH   | latch ROM word at pc into IR
//   DECODE  | op stable, choose EXEC or MEM from decoder outputs
//   EXEC    | ALU/LDI write strobe or BNE pc update
//   MEM     | data-memory request until ack or timeout
//   WB      | load data written back to the register file
//   HALT    | taken BNE with zero offset
//   ERR     | data-memory timeout
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic           clk,
  input  logic           reset,
  cpu_sequencer_if.master bus
);

  seq_state_t                  state_q, state_d;
  logic [INSTR_W-1:0]          ir_q, ir_d;
  logic [PC_W-1:0]             pc_q, pc_d;
  logic [CNT_W-1:0]            retired_q, retired_d;
  logic [OP_W-1:0]             op;
  logic signed [BNE_OFF_W-1:0] bne_off;
  logic [PC_W-1:0]             pc_inc;
  logic [PC_W-1:0]             pc_branch;
  logic                        bne_halt;
  logic                        retire;
  logic                        mem_timeout;
  logic                        rf_we;
  logic                        wb_sel_mem;
  logic                        mem_req;
  logic                        mem_we;

  assign op        = ir_q[OP_LSB +: OP_W];
  assign bne_off   = ir_q[BNE_OFF_LSB +: BNE_OFF_W];
  assign pc_inc    = pc_q + PC_W'(1);
  assign pc_branch = pc_q + PC_W'(bne_off);
  assign bne_halt  = (op == kBNE) && bus.bne_taken && (bne_off == '0);

  seq_wait_timer #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .run_i     (state_q == S_MEM),
    .ack_i     (bus.mem_ack),
    .timeout_o (mem_timeout)
  );

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    retired_d  = retired_q;
    retire     = 1'b0;
    rf_we      = 1'b0;
    wb_sel_mem = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE, S_HALT, S_ERR: begin
        if (bus.start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          retired_d = '0;
        end
      end
      S_FETCH: begin
        ir_d    = bus.instr;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = (bus.dec_str || bus.dec_ldr) ? S_MEM : S_EXEC;
      end
      S_EXEC: begin
        if (op == kBNE) begin
          pc_d = bus.bne_taken ? pc_branch : pc_inc;
        end else begin
          rf_we = bus.dec_rf_we;
          pc_d  = pc_inc;
        end
        state_d = bne_halt ? S_HALT : S_FETCH;
        retire  = !bne_halt;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = bus.dec_str;
        if (bus.mem_ack) begin
          if (bus.dec_ldr) begin
            state_d = S_WB;
          end else begin
            pc_d    = pc_inc;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (mem_timeout) begin
          state_d = S_ERR;
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        wb_sel_mem = 1'b1;
        pc_d       = pc_inc;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    if (retire && (retired_q != '1)) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      pc_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  assign bus.op         = op;
  assign bus.pc         = pc_q;
  assign bus.retired    = retired_q;
  assign bus.rf_we      = rf_we;
  assign bus.wb_sel_mem = wb_sel_mem;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.busy       = !is_parked(state_q);
  assign bus.halted     = (state_q == S_HALT);
  assign bus.err        = (state_q == S_ERR);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus queues expected events, a
// negedge monitor turns rf_we / memory / halt / error activity into events.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  localparam int PC_W        = 8;
  localparam int CNT_W       = 16;
  localparam int MEM_TIMEOUT = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  cpu_sequencer #(
    .PC_W        (PC_W),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [INSTR_W-1:0] rom [256];
  assign bus.instr = rom[bus.pc];

  // ctrl_dec model
  always_comb begin
    bus.dec_str   = (bus.op == kSTR);
    bus.dec_ldr   = (bus.op == kLDM);
    bus.dec_rf_we = !((bus.op == kSTR) || (bus.op == kBNE));
  end

  typedef enum int {EV_RFWE, EV_MEM, EV_HALT, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       pc;
    int       n;
    int       flag;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  task automatic expect_ev(ev_kind_e k, int pc, int n, int flag);
    ev_t e;
    e.kind = k; e.pc = pc; e.n = n; e.flag = flag;
    exp_q.push_back(e);
  endtask

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic observe(ev_t a);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got pc=%0d n=%0d flag=%0d, expected no event",
               a.kind.name(), a.pc, a.n, a.flag);
    end else begin
      e = exp_q.pop_front();
      if ((a.kind != e.kind) || (a.pc != e.pc) || (a.n != e.n) || (a.flag != e.flag)) begin
        n_fail++;
        $display("FAIL ev_%s: got %s pc=%0d n=%0d flag=%0d, expected %s pc=%0d n=%0d flag=%0d",
                 e.kind.name(), a.kind.name(), a.pc, a.n, a.flag,
                 e.kind.name(), e.pc, e.n, e.flag);
      end
    end
  endtask

  // Monitor: rf_we -> {pc, retired, wb_sel_mem}; end of mem_req run ->
  // {pc, cycles, mem_we (2 if it changed)}; halted/err rise -> {pc, retired, x}.
  initial begin
    int   req_run;
    logic we_or, we_and, prev_req, prev_halt, prev_err;
    ev_t  a;
    req_run = 0; we_or = 1'b0; we_and = 1'b1;
    prev_req = 1'b0; prev_halt = 1'b0; prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        req_run = 0; prev_req = 1'b0; prev_halt = 1'b0; prev_err = 1'b0;
      end else begin
        if (bus.mem_req) begin
          if (!prev_req) begin
            req_run = 0; we_or = 1'b0; we_and = 1'b1;
          end
          req_run++;
          we_or  = we_or | bus.mem_we;
          we_and = we_and & bus.mem_we;
        end else if (prev_req) begin
          a.kind = EV_MEM; a.pc = int'(bus.pc); a.n = req_run;
          a.flag = (we_or == we_and) ? int'(we_or) : 2;
          observe(a);
        end
        if (bus.rf_we) begin
          a.kind = EV_RFWE; a.pc = int'(bus.pc); a.n = int'(bus.retired);
          a.flag = int'(bus.wb_sel_mem);
          observe(a);
        end
        if (bus.halted && !prev_halt) begin
          a.kind = EV_HALT; a.pc = int'(bus.pc); a.n = int'(bus.retired);
          a.flag = int'(bus.err);
          observe(a);
        end
        if (bus.err && !prev_err) begin
          a.kind = EV_ERR; a.pc = int'(bus.pc); a.n = int'(bus.retired);
          a.flag = int'(bus.mem_req);
          observe(a);
        end
        prev_req  = bus.mem_req;
        prev_halt = bus.halted;
        prev_err  = bus.err;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_pc(int v, string name);
    int n = 0;
    while ((int'(bus.pc) != v) && (n < 200)) begin
      tick();
      n++;
    end
    chk(name, int'(bus.pc), v);
  endtask

  task automatic wait_halt(string name);
    int n = 0;
    while (!bus.halted && (n < 200)) begin
      tick();
      n++;
    end
    chk(name, int'(bus.halted), 1);
    repeat (2) tick();
  endtask

  task automatic wait_mem_req(string name);
    int n = 0;
    while (!bus.mem_req && (n < 50)) begin
      tick();
      n++;
    end
    chk(name, int'(bus.mem_req), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m;
    for (int i = 0; i < 256; i++) rom[i] = {kADD, 6'd0};
    bus.start     = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.bne_taken = 1'b1;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_pc", int'(bus.pc), 0);
    chk("rst_op", int'(bus.op), 0);
    chk("rst_retired", int'(bus.retired), 0);
    chk("rst_flags", int'({bus.busy, bus.halted, bus.err, bus.mem_req,
                           bus.mem_we, bus.rf_we, bus.wb_sel_mem}), 0);

    // ADD, XOR, LDI, BNE +0 taken; start pulsed again during first EXEC
    rom[0] = {kADD, 6'd1};
    rom[1] = {kXOR, 6'd2};
    rom[2] = {kLDI, 6'd5};
    rom[3] = {kBNE, 6'd0};
    expect_ev(EV_RFWE, 0, 0, 0);
    expect_ev(EV_RFWE, 1, 1, 0);
    expect_ev(EV_RFWE, 2, 2, 0);
    expect_ev(EV_HALT, 3, 3, 0);
    start_pulse();
    n = 0;
    while (!bus.halted && (n < 100)) begin
      bus.start = (n == 2);
      tick();
      n++;
    end
    bus.start = 1'b0;
    chk("prog_halt_cycles", n, 12);
    chk("prog_pc", int'(bus.pc), 3);
    chk("prog_retired", int'(bus.retired), 3);
    repeat (2) tick();

    // LDM with ack on third MEM cycle (and a stray ack during DECODE)
    rom[0] = {kLDM, 6'd2};
    rom[1] = {kBNE, 6'd0};
    expect_ev(EV_MEM, 0, 3, 0);
    expect_ev(EV_RFWE, 0, 0, 1);
    expect_ev(EV_HALT, 1, 1, 0);
    start_pulse();
    n = 0; m = 0;
    while ((int'(bus.pc) != 1) && (n < 50)) begin
      bus.mem_ack = (bus.mem_req && (m == 2)) || (n == 1);
      if (bus.mem_req) m++;
      tick();
      n++;
    end
    bus.mem_ack = 1'b0;
    chk("ldm_cycles", n, 6);
    wait_halt("ldm_halt");

    // ADD then STR with no ack: timeout after MEM_TIMEOUT cycles
    rom[0] = {kADD, 6'd0};
    rom[1] = {kSTR, 6'd1};
    expect_ev(EV_RFWE, 0, 0, 0);
    expect_ev(EV_MEM, 1, 4, 1);
    expect_ev(EV_ERR, 1, 1, 0);
    start_pulse();
    wait_mem_req("str_req");
    n = 0;
    while (!bus.err && (n < 20)) begin
      tick();
      n++;
    end
    chk("str_timeout_cycles", n, 4);
    chk("str_err_mem_req", int'(bus.mem_req), 0);
    chk("str_err_retired", int'(bus.retired), 1);
    repeat (2) tick();

    // restart from ERR
    rom[0] = {kBNE, 6'd0};
    expect_ev(EV_HALT, 0, 0, 0);
    start_pulse();
    chk("restart_pc", int'(bus.pc), 0);
    chk("restart_err", int'(bus.err), 0);
    wait_halt("restart_halt");

    // BNE -2 at pc 5: taken -> 3, then not taken -> 6
    for (int i = 0; i < 5; i++) rom[i] = {kADD, 6'd0};
    rom[5] = {kBNE, 6'b111110};
    rom[6] = {kBNE, 6'd0};
    for (int i = 0; i < 5; i++) expect_ev(EV_RFWE, i, i, 0);
    expect_ev(EV_RFWE, 3, 6, 0);
    expect_ev(EV_RFWE, 4, 7, 0);
    expect_ev(EV_HALT, 6, 9, 0);
    bus.bne_taken = 1'b1;
    start_pulse();
    wait_pc(5, "bne_reach5");
    wait_pc(3, "bne_taken_m2");
    bus.bne_taken = 1'b0;
    wait_pc(6, "bne_not_taken");
    bus.bne_taken = 1'b1;
    wait_halt("bne_halt");

    // BNE -1 at pc 0 wraps to 255; ADD at 255 wraps back to 0
    rom[0]   = {kBNE, 6'h3F};
    rom[255] = {kADD, 6'd0};
    expect_ev(EV_RFWE, 255, 1, 0);
    expect_ev(EV_HALT, 0, 2, 0);
    start_pulse();
    wait_pc(255, "bne_wrap_255");
    rom[0] = {kBNE, 6'd0};
    wait_halt("wrap_halt");
    chk("wrap_pc", int'(bus.pc), 0);

    // asynchronous reset while in MEM
    rom[0] = {kADD, 6'd0};
    rom[1] = {kLDM, 6'd0};
    expect_ev(EV_RFWE, 0, 0, 0);
    start_pulse();
    wait_mem_req("rst_mem_req_up");
    #2 reset = 1'b1;
    #1;
    chk("rst_async_mem_req", int'(bus.mem_req), 0);
    chk("rst_async_busy", int'(bus.busy), 0);
    chk("rst_async_pc", int'(bus.pc), 0);
    chk("rst_async_retired", int'(bus.retired), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) tick();
    chk("post_rst_busy", int'(bus.busy), 0);

    repeat (3) tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
